// File: rtl/ser_dbg_master.sv
// UART debug master: 'W'/'R' commands received over 8N1 serial become one-cycle device-bus strobes.
// Latency: bus strobe 1 clk after the last command byte's mid-stop; response frames follow back-to-back.
// No backpressure: bytes arriving while a command executes or responds are dropped.
module ser_dbg_master #(
    parameter int unsigned CLK_DIV = 434,
    parameter int unsigned TIMEOUT = 1000000,
    parameter logic [3:0]  CTL_NOP = 4'd0,
    parameter logic [3:0]  CTL_RD  = 4'd1,
    parameter logic [3:0]  CTL_WR  = 4'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ser_rxd,
    output logic        ser_txd,
    output logic [31:0] cop_addr_o,
    output logic [31:0] cop_data_o,
    output logic [3:0]  cop_mem_ctl_o,
    input  logic [31:0] cop_dout,
    output logic        busy_o
);
    localparam logic [15:0] BIT_M1  = 16'(CLK_DIV - 1);
    localparam logic [15:0] HALF_M1 = 16'(CLK_DIV / 2 - 1);
    localparam logic [31:0] TMO_MAX = 32'(TIMEOUT);

    typedef enum logic [1:0] {RX_HUNT, RX_START, RX_DATA, RX_STOP} rx_st_e;
    typedef enum logic [2:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_BUS, ST_RDWAIT, ST_RESP} st_e;

    logic        rxd_meta_q, rxd_sync_q, rxd_prev_q;
    rx_st_e      rx_st_q, rx_st_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [3:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic        rx_vld;

    st_e         st_q, st_d;
    logic        op_wr_q, op_wr_d;
    logic [2:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] tmo_q, tmo_d;
    logic [31:0] addr_q, addr_d, data_q, data_d;
    logic [31:0] tx_buf_q, tx_buf_d;
    logic [2:0]  tx_left_q, tx_left_d;
    logic        tx_busy_q, tx_busy_d;
    logic [9:0]  tx_sh_q, tx_sh_d;
    logic [3:0]  tx_bit_q, tx_bit_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic        tx_load;

    // RX: edge-triggered start, glitch recheck at mid start bit, mid-bit sampling
    always_comb begin
        rx_st_d  = rx_st_q;
        rx_cnt_d = rx_cnt_q;
        rx_bit_d = rx_bit_q;
        rx_sh_d  = rx_sh_q;
        rx_vld   = 1'b0;
        unique case (rx_st_q)
            RX_HUNT: begin
                if (rxd_prev_q && !rxd_sync_q) begin
                    rx_st_d  = RX_START;
                    rx_cnt_d = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_M1) begin
                    rx_cnt_d = '0;
                    rx_bit_d = '0;
                    rx_st_d  = rxd_sync_q ? RX_HUNT : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_M1) begin
                    rx_cnt_d = '0;
                    rx_sh_d  = {rxd_sync_q, rx_sh_q[7:1]};
                    rx_bit_d = rx_bit_q + 4'd1;
                    if (rx_bit_q == 4'd7) rx_st_d = RX_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_M1) begin
                    rx_cnt_d = '0;
                    rx_st_d  = RX_HUNT;
                    rx_vld   = rxd_sync_q;
                end else begin
                    rx_cnt_d = rx_cnt_q + 16'd1;
                end
            end
            default: rx_st_d = RX_HUNT;
        endcase
    end

    always_comb begin
        st_d       = st_q;
        op_wr_d    = op_wr_q;
        byte_cnt_d = byte_cnt_q;
        tmo_d      = tmo_q;
        addr_d     = addr_q;
        data_d     = data_q;
        tx_buf_d   = tx_buf_q;
        tx_left_d  = tx_left_q;
        tx_busy_d  = tx_busy_q;
        tx_sh_d    = tx_sh_q;
        tx_bit_d   = tx_bit_q;
        tx_cnt_d   = tx_cnt_q;
        tx_load    = 1'b0;

        // TX: next queued frame loads in the same cycle the previous stop bit ends
        if (!tx_busy_q) begin
            tx_load = (tx_left_q != 3'd0);
        end else if (tx_cnt_q == BIT_M1) begin
            tx_cnt_d = '0;
            if (tx_bit_q == 4'd9) begin
                tx_load   = (tx_left_q != 3'd0);
                tx_busy_d = 1'b0;
            end else begin
                tx_sh_d  = {1'b1, tx_sh_q[9:1]};
                tx_bit_d = tx_bit_q + 4'd1;
            end
        end else begin
            tx_cnt_d = tx_cnt_q + 16'd1;
        end
        if (tx_load) begin
            tx_sh_d   = {1'b1, tx_buf_q[31:24], 1'b0};
            tx_buf_d  = {tx_buf_q[23:0], 8'h00};
            tx_left_d = tx_left_q - 3'd1;
            tx_bit_d  = '0;
            tx_cnt_d  = '0;
            tx_busy_d = 1'b1;
        end

        unique case (st_q)
            ST_IDLE: begin
                if (rx_vld) begin
                    if (rx_sh_q == 8'h57 || rx_sh_q == 8'h52) begin
                        op_wr_d    = (rx_sh_q == 8'h57);
                        byte_cnt_d = '0;
                        tmo_d      = '0;
                        st_d       = ST_ADDR;
                    end else begin
                        tx_buf_d  = {8'h15, 24'h0};
                        tx_left_d = 3'd1;
                        st_d      = ST_RESP;
                    end
                end
            end
            ST_ADDR, ST_DATA: begin
                if (rx_vld) begin
                    if (st_q == ST_ADDR) addr_d = {addr_q[23:0], rx_sh_q};
                    else                 data_d = {data_q[23:0], rx_sh_q};
                    tmo_d      = '0;
                    byte_cnt_d = byte_cnt_q + 3'd1;
                    if (byte_cnt_q == 3'd3) begin
                        byte_cnt_d = '0;
                        st_d = (st_q == ST_ADDR && op_wr_q) ? ST_DATA : ST_BUS;
                    end
                end else if (tmo_q == TMO_MAX) begin
                    tmo_d = '0;
                    st_d  = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            ST_BUS: begin
                if (op_wr_q) begin
                    tx_buf_d  = {8'h06, 24'h0};
                    tx_left_d = 3'd1;
                    st_d      = ST_RESP;
                end else begin
                    st_d = ST_RDWAIT;
                end
            end
            ST_RDWAIT: begin
                tx_buf_d  = cop_dout;
                tx_left_d = 3'd4;
                st_d      = ST_RESP;
            end
            ST_RESP: begin
                if (tx_left_q == 3'd0 && !tx_busy_q) st_d = ST_IDLE;
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
            rx_st_q    <= RX_HUNT;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            st_q       <= ST_IDLE;
            op_wr_q    <= 1'b0;
            byte_cnt_q <= '0;
            tmo_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            tx_buf_q   <= '0;
            tx_left_q  <= '0;
            tx_busy_q  <= 1'b0;
            tx_sh_q    <= '1;
            tx_bit_q   <= '0;
            tx_cnt_q   <= '0;
        end else begin
            rxd_meta_q <= ser_rxd;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
            rx_st_q    <= rx_st_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            st_q       <= st_d;
            op_wr_q    <= op_wr_d;
            byte_cnt_q <= byte_cnt_d;
            tmo_q      <= tmo_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            tx_buf_q   <= tx_buf_d;
            tx_left_q  <= tx_left_d;
            tx_busy_q  <= tx_busy_d;
            tx_sh_q    <= tx_sh_d;
            tx_bit_q   <= tx_bit_d;
            tx_cnt_q   <= tx_cnt_d;
        end
    end

    // Strobe and busy are decoded from state, gated so reset cycles never show a strobe
    assign ser_txd       = tx_sh_q[0];
    assign cop_addr_o    = addr_q;
    assign cop_data_o    = data_q;
    assign cop_mem_ctl_o = (!rst && st_q == ST_BUS) ? (op_wr_q ? CTL_WR : CTL_RD) : CTL_NOP;
    assign busy_o        = !rst && ((st_q == ST_ADDR && byte_cnt_q != 3'd0) || st_q == ST_DATA ||
                                    st_q == ST_BUS || st_q == ST_RDWAIT || st_q == ST_RESP);
endmodule

// File: tb/tb_ser_dbg_master.sv
// Bench for ser_dbg_master: UART driver/decoder, bus-strobe monitor and a command-level expectation model.
// Directed scenarios (write, read, NAK, timeout, framing, glitch, reset) plus randomized commands.
module tb_ser_dbg_master;
    localparam int CLK_DIV = 4;
    localparam int TIMEOUT = 200;
    localparam logic [3:0] C_NOP = 4'd0;
    localparam logic [3:0] C_RD  = 4'd1;
    localparam logic [3:0] C_WR  = 4'd2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ser_rxd = 1'b1;
    logic        ser_txd;
    logic [31:0] cop_addr_o, cop_data_o;
    logic [31:0] cop_dout = 32'h0;
    logic [3:0]  cop_mem_ctl_o;
    logic        busy_o;

    always #5 clk = ~clk;

    ser_dbg_master #(.CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT),
                     .CTL_NOP(C_NOP), .CTL_RD(C_RD), .CTL_WR(C_WR)) dut (
        .clk(clk), .rst(rst), .ser_rxd(ser_rxd), .ser_txd(ser_txd),
        .cop_addr_o(cop_addr_o), .cop_data_o(cop_data_o), .cop_mem_ctl_o(cop_mem_ctl_o),
        .cop_dout(cop_dout), .busy_o(busy_o));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observed traffic
    logic [3:0]  bus_ctl_q[$];
    logic [31:0] bus_addr_q[$], bus_data_q[$];
    logic [7:0]  tx_q[$];
    int          tx_t[$];
    // Expected traffic and model of the held address/data registers
    logic [3:0]  exp_ctl[$];
    logic [31:0] exp_addr[$], exp_data[$];
    logic [7:0]  exp_tx[$];
    logic [31:0] mdl_data = 32'h0;
    logic [31:0] rd_val = 32'h0;

    initial forever begin
        @(negedge clk);
        if (cop_mem_ctl_o !== C_NOP) begin
            bus_ctl_q.push_back(cop_mem_ctl_o);
            bus_addr_q.push_back(cop_addr_o);
            bus_data_q.push_back(cop_data_o);
        end
    end

    // Read data is only meaningful in the clock after the read strobe
    logic prev_rd = 1'b0;
    initial forever begin
        @(posedge clk);
        #1;
        cop_dout = prev_rd ? rd_val : $urandom;
        prev_rd  = (cop_mem_ctl_o == C_RD);
    end

    logic [7:0] mon_b;
    int         mon_t;
    initial forever begin
        @(negedge clk);
        if (ser_txd === 1'b0 && !rst) begin
            mon_t = cyc;
            repeat (2) @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                repeat (CLK_DIV) @(negedge clk);
                mon_b[i] = ser_txd;
            end
            repeat (CLK_DIV) @(negedge clk);
            check("tx_stop_bit", 64'(ser_txd), 64'(1));
            tx_q.push_back(mon_b);
            tx_t.push_back(mon_t);
        end
    end

    task automatic drive_bit(input logic v);
        ser_rxd = v;
        repeat (CLK_DIV) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
        @(posedge clk);
        #1;
        drive_bit(1'b1);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_bit);
        ser_rxd = 1'b1;
        repeat (CLK_DIV * $urandom_range(0, 2)) @(posedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
    endtask

    task automatic settle();
        int w = 0;
        while (tx_q.size() < exp_tx.size() && w < 800) begin
            @(negedge clk);
            w++;
        end
        repeat (60) @(negedge clk);
        check("bus_count", 64'(bus_ctl_q.size()), 64'(exp_ctl.size()));
        for (int k = 0; k < exp_ctl.size() && k < bus_ctl_q.size(); k++) begin
            check($sformatf("bus_ctl[%0d]", k),  64'(bus_ctl_q[k]),  64'(exp_ctl[k]));
            check($sformatf("bus_addr[%0d]", k), 64'(bus_addr_q[k]), 64'(exp_addr[k]));
            check($sformatf("bus_data[%0d]", k), 64'(bus_data_q[k]), 64'(exp_data[k]));
        end
        check("tx_count", 64'(tx_q.size()), 64'(exp_tx.size()));
        for (int k = 0; k < exp_tx.size() && k < tx_q.size(); k++) begin
            check($sformatf("tx_byte[%0d]", k), 64'(tx_q[k]), 64'(exp_tx[k]));
            if (k > 0) check($sformatf("tx_gap[%0d]", k), 64'(tx_t[k] - tx_t[k-1]), 64'(10 * CLK_DIV));
        end
        check("busy_idle", 64'(busy_o), 64'(0));
        check("txd_idle", 64'(ser_txd), 64'(1));
        bus_ctl_q.delete(); bus_addr_q.delete(); bus_data_q.delete();
        tx_q.delete(); tx_t.delete();
        exp_ctl.delete(); exp_addr.delete(); exp_data.delete(); exp_tx.delete();
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input bit inject_bad = 1'b0);
        send_byte(8'h57);
        send_byte(a[31:24]);
        send_byte(a[23:16]);
        if (inject_bad) send_byte(8'h99, 1'b0);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
        send_word(d);
        exp_ctl.push_back(C_WR); exp_addr.push_back(a); exp_data.push_back(d);
        exp_tx.push_back(8'h06);
        mdl_data = d;
        settle();
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] v, input bit poke = 1'b0);
        int w = 0;
        rd_val = v;
        send_byte(8'h52);
        send_word(a);
        if (poke) send_byte(8'h41);
        exp_ctl.push_back(C_RD); exp_addr.push_back(a); exp_data.push_back(mdl_data);
        for (int i = 3; i >= 0; i--) exp_tx.push_back(v[8*i +: 8]);
        while (busy_o !== 1'b0 && w < 800) begin
            @(negedge clk);
            w++;
        end
        check("rd_tx_done_at_busy_fall", 64'(tx_q.size()), 64'(4));
        settle();
    endtask

    task automatic do_bad(input logic [7:0] op);
        send_byte(op);
        exp_tx.push_back(8'h15);
        settle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_txd"},  64'(ser_txd),       64'(1));
        check({tag, "_addr"}, 64'(cop_addr_o),    64'(0));
        check({tag, "_data"}, 64'(cop_data_o),    64'(0));
        check({tag, "_ctl"},  64'(cop_mem_ctl_o), 64'(C_NOP));
        check({tag, "_busy"}, 64'(busy_o),        64'(0));
    endtask

    initial begin
        logic [7:0] op;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(posedge clk);

        do_write(32'h0000_0010, 32'hDEAD_BEEF);
        do_read(32'h0000_0020, 32'h1234_5678);
        do_bad(8'h41);
        do_write(32'hCAFE_0004, 32'h0BAD_F00D);
        // byte arriving during the read response is dropped without a NAK
        do_read(32'h0000_0030, 32'hA5A5_5A5A, 1'b1);

        // inter-byte timeout aborts silently, next read works
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h00);
        repeat (250) @(posedge clk);
        settle();
        do_read(32'h0000_0040, $urandom);

        // framing error in IDLE, and inside an address field
        send_byte(8'h41, 1'b0);
        settle();
        do_write(32'h1122_3344, 32'h5566_7788, 1'b1);

        // single-clock glitch
        @(posedge clk);
        #1;
        ser_rxd = 1'b0;
        @(posedge clk);
        #1;
        ser_rxd = 1'b1;
        settle();

        // reset after the third address byte of a write
        send_byte(8'h57);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midcmd_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        mdl_data = 32'h0;
        settle();
        do_read(32'h0000_0050, 32'h8765_4321);

        for (int n = 0; n < 8; n++) begin
            case ($urandom_range(0, 2))
                0: do_write($urandom, $urandom);
                1: do_read($urandom, $urandom);
                default: begin
                    op = 8'($urandom);
                    if (op == 8'h57 || op == 8'h52) op = 8'h00;
                    do_bad(op);
                end
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d, expected completion", cyc);
        $fatal(1);
    end
endmodule
